// File: rtl/pkt_fifo.sv
// Packet-mode showahead FIFO: words are stored speculatively and become readable only when their packet commits.
// Optional macro PKT_FIFO_PKT_CNT_EN adds pkt_cnt_o, the count of committed packets not yet fully popped.
module pkt_fifo #(
  parameter int DWIDTH             = 64,
  parameter int AWIDTH             = 10,
  parameter int ALMOST_FULL_VALUE  = 12,
  parameter int ALMOST_EMPTY_VALUE = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              sop_i,
  input  logic              eop_i,
  input  logic              err_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              q_sop_o,
  output logic              q_eop_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              drop_o
`ifdef PKT_FIFO_PKT_CNT_EN
  ,
  output logic [AWIDTH:0]   pkt_cnt_o
`endif
);

  localparam int              DEPTH   = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH:0] ONE_W   = (AWIDTH + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_OVF  = 2'd2
  } wr_state_e;

  logic [DWIDTH+1:0] mem [DEPTH];

  wr_state_e         state_q;
  logic [AWIDTH:0]   wr_ptr_q, commit_ptr_q, rd_ptr_q, fetch_ptr_q, usedw_q;
  logic              drop_q;
  logic [DWIDTH+1:0] ram_q, out_q;
  logic              ram_vld_q, out_vld_q;

  logic [AWIDTH:0]   wr_used_s, base_s, rd_ptr_d;
  logic              base_full_s, pop_s, ram_to_out_s, ren_s;

  // A new sop restarts at commit_ptr, discarding any open packet, so space is judged from there.
  assign base_s       = sop_i ? commit_ptr_q : wr_ptr_q;
  assign base_full_s  = ((base_s - rd_ptr_q) == DEPTH_W);
  assign wr_used_s    = wr_ptr_q - rd_ptr_q;

  assign pop_s        = rdreq_i & out_vld_q;
  assign ram_to_out_s = ram_vld_q & (~out_vld_q | pop_s);
  assign ren_s        = (fetch_ptr_q != commit_ptr_q) & (~ram_vld_q | ram_to_out_s);
  assign rd_ptr_d     = rd_ptr_q + {{AWIDTH{1'b0}}, pop_s};

  assign q_o            = out_q[DWIDTH-1:0];
  assign q_sop_o        = out_q[DWIDTH+1];
  assign q_eop_o        = out_q[DWIDTH];
  assign empty_o        = ~out_vld_q;
  assign full_o         = (wr_used_s == DEPTH_W);
  assign usedw_o        = usedw_q;
  assign almost_full_o  = (int'(wr_used_s) >= ALMOST_FULL_VALUE);
  assign almost_empty_o = (int'(usedw_q) < ALMOST_EMPTY_VALUE);
  assign drop_o         = drop_q;

  // Write FSM: speculative store, commit on clean eop, rewind to commit_ptr on any discard.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      drop_q       <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (wrreq_i) begin
        case (state_q)
          ST_IDLE, ST_PKT: begin
            if (!sop_i && (state_q == ST_IDLE)) begin
              drop_q <= 1'b1;
            end else begin
              if (sop_i && (state_q == ST_PKT)) begin
                drop_q <= 1'b1;
              end
              if (base_full_s) begin
                if (eop_i) begin
                  wr_ptr_q <= commit_ptr_q;
                  drop_q   <= 1'b1;
                  state_q  <= ST_IDLE;
                end else begin
                  state_q  <= ST_OVF;
                end
              end else begin
                mem[base_s[AWIDTH-1:0]] <= {sop_i, eop_i, data_i};
                if (!eop_i) begin
                  wr_ptr_q <= base_s + ONE_W;
                  state_q  <= ST_PKT;
                end else if (err_i) begin
                  wr_ptr_q <= commit_ptr_q;
                  drop_q   <= 1'b1;
                  state_q  <= ST_IDLE;
                end else begin
                  wr_ptr_q     <= base_s + ONE_W;
                  commit_ptr_q <= base_s + ONE_W;
                  state_q      <= ST_IDLE;
                end
              end
            end
          end
          ST_OVF: begin
            if (eop_i) begin
              wr_ptr_q <= commit_ptr_q;
              drop_q   <= 1'b1;
              state_q  <= ST_IDLE;
            end
          end
          default: begin
            wr_ptr_q <= commit_ptr_q;
            state_q  <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Synchronous RAM read port; holds its word while the output register is occupied.
  always_ff @(posedge clk_i) begin
    if (ren_s) begin
      ram_q <= mem[fetch_ptr_q[AWIDTH-1:0]];
    end
  end

  // Prefetch pipeline feeding the showahead output register, plus read-side occupancy.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      fetch_ptr_q <= '0;
      rd_ptr_q    <= '0;
      ram_vld_q   <= 1'b0;
      out_vld_q   <= 1'b0;
      out_q       <= '0;
      usedw_q     <= '0;
    end else begin
      fetch_ptr_q <= fetch_ptr_q + {{AWIDTH{1'b0}}, ren_s};
      ram_vld_q   <= ren_s | (ram_vld_q & ~ram_to_out_s);
      if (ram_to_out_s) begin
        out_q     <= ram_q;
        out_vld_q <= 1'b1;
      end else if (pop_s) begin
        out_vld_q <= 1'b0;
      end
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= commit_ptr_q - rd_ptr_d;
    end
  end

`ifdef PKT_FIFO_PKT_CNT_EN
  logic              commit_s;
  logic [AWIDTH:0]   pkt_cnt_q;

  assign commit_s  = wrreq_i & eop_i & ~err_i & ~base_full_s &
                     ((state_q == ST_PKT) | ((state_q == ST_IDLE) & sop_i));
  assign pkt_cnt_o = pkt_cnt_q;

  // Committed packets still (partly) in the FIFO; a packet leaves when its eop word is popped.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_q + {{AWIDTH{1'b0}}, commit_s} - {{AWIDTH{1'b0}}, pop_s & q_eop_o};
    end
  end
`endif

endmodule

// File: tb/tb_pkt_fifo.sv
// Directed bench for pkt_fifo (AWIDTH=4) with a scoreboard of committed words checked on every pop.
module tb_pkt_fifo;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          srst_i = 1'b1;
  logic [DW-1:0] data_i = '0;
  logic          sop_i = 1'b0, eop_i = 1'b0, err_i = 1'b0, wrreq_i = 1'b0, rdreq_i = 1'b0;
  logic [DW-1:0] q_o;
  logic          q_sop_o, q_eop_o, empty_o, full_o, almost_full_o, almost_empty_o, drop_o;
  logic [AW:0]   usedw_o;
`ifdef PKT_FIFO_PKT_CNT_EN
  logic [AW:0]   pkt_cnt_o;
`endif

  always #5 clk = ~clk;

  pkt_fifo #(.DWIDTH(DW), .AWIDTH(AW), .ALMOST_FULL_VALUE(12), .ALMOST_EMPTY_VALUE(2)) dut (
    .clk_i(clk), .srst_i(srst_i), .data_i(data_i), .sop_i(sop_i), .eop_i(eop_i), .err_i(err_i),
    .wrreq_i(wrreq_i), .rdreq_i(rdreq_i), .q_o(q_o), .q_sop_o(q_sop_o), .q_eop_o(q_eop_o),
    .empty_o(empty_o), .full_o(full_o), .usedw_o(usedw_o), .almost_full_o(almost_full_o),
    .almost_empty_o(almost_empty_o), .drop_o(drop_o)
`ifdef PKT_FIFO_PKT_CNT_EN
    , .pkt_cnt_o(pkt_cnt_o)
`endif
  );

  int            vectors = 0;
  int            miscompares = 0;
  int            drop_seen = 0;
  int            full_seen = 0;
  logic [DW+1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, score any pop about to happen, then drive the next inputs.
  task automatic step(input logic wr, input logic s, input logic e, input logic er,
                      input logic [DW-1:0] d, input logic rd);
    logic [DW+1:0] exp;
    @(negedge clk);
    if (drop_o) drop_seen++;
    if (full_o) full_seen++;
    if (rd && !empty_o) begin
      vectors++;
      assert (sb.size() != 0) else begin
        miscompares++;
        $error("FAIL pop_unexpected observed=%0h expected=none", {q_sop_o, q_eop_o, q_o});
      end
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("pop_word", 32'({q_sop_o, q_eop_o, q_o}), 32'(exp));
      end
    end
    wrreq_i = wr; sop_i = s; eop_i = e; err_i = er; data_i = d; rdreq_i = rd;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic send_pkt(input int n, input int base, input logic er, input logic good);
    for (int i = 0; i < n; i++) begin
      step(1'b1, i == 0, i == n - 1, er && (i == n - 1), 16'(base + i), 1'b0);
      if (good) sb.push_back({i == 0, i == n - 1, 16'(base + i)});
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 64) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      guard++;
    end
    chk("drain_left", 32'(sb.size()), 32'(0));
    idle();
    chk("drain_empty", 32'(empty_o), 32'(1));
  endtask

  initial begin
    int d0, f0;
    // Reset state
    idle(); idle();
    srst_i = 1'b0;
    chk("rst_empty", 32'(empty_o), 32'(1));
    chk("rst_full", 32'(full_o), 32'(0));
    chk("rst_usedw", 32'(usedw_o), 32'(0));
    chk("rst_aempty", 32'(almost_empty_o), 32'(1));
    chk("rst_afull", 32'(almost_full_o), 32'(0));
    chk("rst_drop", 32'(drop_o), 32'(0));
    chk("rst_qsop", 32'(q_sop_o), 32'(0));
    chk("rst_qeop", 32'(q_eop_o), 32'(0));

    // 4-word packet, commit latency, showahead pops
    send_pkt(4, 'h10, 1'b0, 1'b1);
    idle();
    chk("t1_empty_n", 32'(empty_o), 32'(1));
    chk("t1_usedw_n", 32'(usedw_o), 32'(0));
    idle();
    chk("t1_usedw_n1", 32'(usedw_o), 32'(4));
    chk("t1_empty_n1", 32'(empty_o), 32'(1));
    idle();
    chk("t1_empty_n2", 32'(empty_o), 32'(0));
    chk("t1_head", 32'(q_o), 32'('h10));
`ifdef PKT_FIFO_PKT_CNT_EN
    chk("t1_pktcnt", 32'(pkt_cnt_o), 32'(1));
`endif
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      chk("t1_usedw_pop", 32'(usedw_o), 32'(4 - k));
      chk("t1_aempty_pop", 32'(almost_empty_o), 32'(k >= 3));
    end
    idle();
    chk("t1_usedw_end", 32'(usedw_o), 32'(0));
    chk("t1_empty_end", 32'(empty_o), 32'(1));
`ifdef PKT_FIFO_PKT_CNT_EN
    chk("t1_pktcnt_end", 32'(pkt_cnt_o), 32'(0));
`endif

    // Errored packet discarded, orphan word ignored, next packet from correct address
    send_pkt(3, 'h20, 1'b1, 1'b0);
    idle();
    chk("t2_drop", 32'(drop_o), 32'(1));
    chk("t2_usedw", 32'(usedw_o), 32'(0));
    idle();
    chk("t2_drop_pulse", 32'(drop_o), 32'(0));
    idle();
    chk("t2_empty", 32'(empty_o), 32'(1));
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0099, 1'b0);
    idle();
    chk("t2_orphan_drop", 32'(drop_o), 32'(1));
    idle(); idle();
    chk("t2_orphan_usedw", 32'(usedw_o), 32'(0));
    send_pkt(2, 'h30, 1'b0, 1'b1);
    drain();

    // Overflow: 10 committed, 8-word packet hits full after 6 words
    send_pkt(10, 'h40, 1'b0, 1'b1);
    idle(); idle();
    chk("t3_usedw10", 32'(usedw_o), 32'(10));
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, i == 7, 1'b0, 16'('h50 + i), 1'b0);
      chk("t3_full", 32'(full_o), 32'(i >= 6));
      chk("t3_afull", 32'(almost_full_o), 32'(i >= 2));
    end
    idle();
    chk("t3_drop", 32'(drop_o), 32'(1));
    chk("t3_full_rewind", 32'(full_o), 32'(0));
    chk("t3_usedw_keep", 32'(usedw_o), 32'(10));
    send_pkt(6, 'h60, 1'b0, 1'b1);
    idle();
    chk("t3_full_again", 32'(full_o), 32'(1));
    drain();

    // sop inside an open packet truncates it
    for (int i = 0; i < 3; i++) step(1'b1, i == 0, 1'b0, 1'b0, 16'('h70 + i), 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b0);
    sb.push_back({1'b1, 1'b0, 16'h0080});
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0081, 1'b0);
    sb.push_back({1'b0, 1'b0, 16'h0081});
    chk("t4_drop", 32'(drop_o), 32'(1));
    step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0082, 1'b0);
    sb.push_back({1'b0, 1'b1, 16'h0082});
    chk("t4_drop_pulse", 32'(drop_o), 32'(0));
    drain();

    // Streaming 1-word packets across several pointer wraps
    d0 = drop_seen;
    f0 = full_seen;
    for (int i = 0; i < 3 * (2 ** AW); i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'('h100 + i), 1'b1);
      sb.push_back({1'b1, 1'b1, 16'('h100 + i)});
    end
    drain();
    chk("t5_no_drop", 32'(drop_seen - d0), 32'(0));
    chk("t5_no_full", 32'(full_seen - f0), 32'(0));

    // Reset mid-packet with committed data present
    send_pkt(2, 'hA0, 1'b0, 1'b1);
    idle(); idle(); idle();
    chk("t6_pre_empty", 32'(empty_o), 32'(0));
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'h00B0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h00B1, 1'b0);
    srst_i = 1'b1;
    idle();
    srst_i = 1'b0;
    sb.delete();
    chk("t6_empty", 32'(empty_o), 32'(1));
    chk("t6_usedw", 32'(usedw_o), 32'(0));
    chk("t6_drop", 32'(drop_o), 32'(0));
    chk("t6_full", 32'(full_o), 32'(0));
    send_pkt(2, 'hC0, 1'b0, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
